// File: rtl/bcd_disp_pkg.sv
// rtl/bcd_disp_pkg.sv - shared constants, scan-state encoding and segment patterns
package bcd_disp_pkg;

  localparam int NUM_DIGITS = 4;

  typedef enum logic [1:0] {
    SCAN0 = 2'd0,
    SCAN1 = 2'd1,
    SCAN2 = 2'd2,
    SCAN3 = 2'd3
  } scan_state_t;

  // Active-low segments, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - combinational BCD digit to active-low 7-segment decoder
module seg7_decode
  import bcd_disp_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_display_mux.sv
// rtl/bcd_display_mux.sv - four-digit multiplexed 7-segment driver with conversion pacing
module bcd_display_mux
  import bcd_disp_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int UPDATE_DIV  = 10000000,
  parameter int BLANK_LZ    = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] bcd_in,
  input  logic        rdy,
  output logic        conv_en,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int RW = $clog2(REFRESH_DIV);
  localparam int UW = $clog2(UPDATE_DIV);
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [UW-1:0] UPDATE_LAST  = UW'(UPDATE_DIV - 1);

  logic [15:0]           held;
  logic [RW-1:0]         refresh_cnt;
  logic [UW-1:0]         update_cnt;
  logic [UW-1:0]         update_next;
  logic                  refresh_tc;
  scan_state_t           state;
  scan_state_t           next_state;
  logic [3:0]            cur_digit;
  logic [6:0]            dec_seg;
  logic [NUM_DIGITS-1:0] nonzero;
  logic [NUM_DIGITS-1:0] blank_vec;
  logic                  slot_blank;
  logic                  lz_en;

  assign lz_en       = (BLANK_LZ != 0);
  assign refresh_tc  = (refresh_cnt == REFRESH_LAST);
  assign update_next = (update_cnt == UPDATE_LAST) ? '0 : update_cnt + UW'(1);
  assign dp          = 1'b1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      held        <= 16'h0000;
      refresh_cnt <= '0;
      update_cnt  <= '0;
      conv_en     <= 1'b0;
    end else begin
      if (rdy) held <= bcd_in;
      refresh_cnt <= refresh_tc ? '0 : refresh_cnt + RW'(1);
      update_cnt  <= update_next;
      // Registered so the pulse lines up with the cycle the counter sits at terminal count
      conv_en     <= (update_next == UPDATE_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= SCAN0;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (refresh_tc) begin
      case (state)
        SCAN0:   next_state = SCAN1;
        SCAN1:   next_state = SCAN2;
        SCAN2:   next_state = SCAN3;
        SCAN3:   next_state = SCAN0;
        default: next_state = SCAN0;
      endcase
    end
  end

  always_comb begin
    cur_digit = held[3:0];
    case (state)
      SCAN0:   cur_digit = held[3:0];
      SCAN1:   cur_digit = held[7:4];
      SCAN2:   cur_digit = held[11:8];
      SCAN3:   cur_digit = held[15:12];
      default: cur_digit = held[3:0];
    endcase
  end

  // A digit is blanked only when it and every digit above it are zero; 10-15 count as nonzero
  always_comb begin
    nonzero   = '0;
    blank_vec = '0;
    for (int i = 0; i < NUM_DIGITS; i++) nonzero[i] = |held[i*4 +: 4];
    blank_vec[1] = lz_en && !(nonzero[3] || nonzero[2] || nonzero[1]);
    blank_vec[2] = lz_en && !(nonzero[3] || nonzero[2]);
    blank_vec[3] = lz_en && !nonzero[3];
  end

  assign slot_blank = blank_vec[state];

  seg7_decode u_decode (
    .digit (cur_digit),
    .seg   (dec_seg)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      an  <= 4'b1111;
      seg <= SEG_BLANK;
    end else if (slot_blank) begin
      an  <= 4'b1111;
      seg <= SEG_BLANK;
    end else begin
      an  <= ~(4'b0001 << state);
      seg <= dec_seg;
    end
  end

endmodule

// File: tb/tb_bcd_display_mux.sv
// tb/tb_bcd_display_mux.sv - scoreboard bench for bcd_display_mux with short dividers
module tb_bcd_display_mux;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] bcd_in;
  logic        rdy;
  logic        conv_en;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int checks = 0;
  int errors = 0;
  int k = 0;
  logic [15:0] m_held = 16'h0000;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       conv;
  } exp_t;

  exp_t sb[$];
  logic [6:0] seg_tab [16];

  always #5 clk = ~clk;

  bcd_display_mux #(
    .REFRESH_DIV (4),
    .UPDATE_DIV  (8),
    .BLANK_LZ    (1)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bcd_in  (bcd_in),
    .rdy     (rdy),
    .conv_en (conv_en),
    .an      (an),
    .seg     (seg),
    .dp      (dp)
  );

  // Output after the kk-th edge since reset release: slot advances every 4 edges,
  // conv_en high in the cycle the 0..7 update counter sits at 7.
  function automatic exp_t model_out(input int kk, input logic [15:0] h);
    exp_t e;
    int slot;
    logic [3:0] d;
    logic [15:0] upper;
    slot  = ((kk - 1) / 4) % 4;
    d     = h[slot*4 +: 4];
    upper = h >> (slot * 4);
    e.conv = ((kk % 8) == 7);
    if (slot != 0 && upper == 16'h0000) begin
      e.an  = 4'b1111;
      e.seg = 7'b1111111;
    end else begin
      e.an  = ~(4'b0001 << slot);
      e.seg = seg_tab[d];
    end
    return e;
  endfunction

  function automatic logic [15:0] rand_bcd();
    return {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
            4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
  endfunction

  task automatic drive_edge(input logic r, input logic [15:0] v);
    rdy    = r;
    bcd_in = r ? v : 16'($urandom);
    sb.push_back(model_out(k + 1, m_held));
    @(posedge clk);
    k++;
    if (r) m_held = v;
    #1;
    rdy = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    reset  = 1'b0;
    rdy    = 1'b0;
    bcd_in = 16'h0000;
    @(posedge clk);
    rdy    = 1'b1;
    bcd_in = 16'h9999;
    @(posedge clk);
    #1;
    checks++;
    if (an !== 4'b1111 || seg !== 7'b1111111 || dp !== 1'b1 || conv_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: an=%b seg=%b dp=%b conv_en=%b, expected an=1111 seg=1111111 dp=1 conv_en=0",
               an, seg, dp, conv_en);
    end
    rdy    = 1'b0;
    reset  = 1'b1;
    k      = 0;
    m_held = 16'h0000;
    repeat (16) begin
      drive_edge(1'b0, 16'h0000);
      e = sb.pop_front();
      checks++;
      if (an !== e.an || seg !== e.seg || conv_en !== e.conv || dp !== 1'b1) begin
        errors++;
        $display("FAIL idle_scan k=%0d: an=%b seg=%b conv_en=%b dp=%b, expected an=%b seg=%b conv_en=%b dp=1",
                 k, an, seg, conv_en, dp, e.an, e.seg, e.conv);
      end
    end
  endtask

  task automatic test_digits();
    exp_t e;
    logic [15:0] vals [7];
    vals = '{16'h1234, 16'h0070, 16'h00A5, 16'h0000, 16'hF000, 16'h5678, 16'h0905};
    foreach (vals[j]) begin
      drive_edge(1'b1, vals[j]);
      repeat (17) begin
        e = sb.pop_front();
        checks++;
        if (an !== e.an || seg !== e.seg || conv_en !== e.conv || dp !== 1'b1) begin
          errors++;
          $display("FAIL digits_%h k=%0d: an=%b seg=%b conv_en=%b, expected an=%b seg=%b conv_en=%b",
                   vals[j], k, an, seg, conv_en, e.an, e.seg, e.conv);
        end
        drive_edge(1'b0, 16'h0000);
      end
      void'(sb.pop_front());
    end
  endtask

  task automatic test_tc_capture();
    exp_t e;
    drive_edge(1'b1, 16'h1234);
    void'(sb.pop_front());
    for (int n = 0; n < 4 && ((k + 1) % 4) != 0; n++) begin
      drive_edge(1'b0, 16'h0000);
      void'(sb.pop_front());
    end
    drive_edge(1'b1, 16'h0380);
    repeat (5) begin
      e = sb.pop_front();
      checks++;
      if (an !== e.an || seg !== e.seg || conv_en !== e.conv) begin
        errors++;
        $display("FAIL tc_capture k=%0d: an=%b seg=%b conv_en=%b, expected an=%b seg=%b conv_en=%b",
                 k, an, seg, conv_en, e.an, e.seg, e.conv);
      end
      drive_edge(1'b0, 16'h0000);
    end
    void'(sb.pop_front());
  endtask

  task automatic test_conv_en();
    exp_t e;
    int rdy_at = -1;
    int pulses = 0;
    int last_pulse = -1;
    logic r;
    repeat (48) begin
      r = (k + 1 == rdy_at);
      drive_edge(r, rand_bcd());
      e = sb.pop_front();
      checks++;
      if (an !== e.an || seg !== e.seg || conv_en !== e.conv) begin
        errors++;
        $display("FAIL conv_en k=%0d: an=%b seg=%b conv_en=%b, expected an=%b seg=%b conv_en=%b",
                 k, an, seg, conv_en, e.an, e.seg, e.conv);
      end
      if (conv_en === 1'b1) begin
        if (last_pulse >= 0) begin
          checks++;
          if (k - last_pulse != 8) begin
            errors++;
            $display("FAIL conv_period: got %0d cycles, expected 8", k - last_pulse);
          end
        end
        last_pulse = k;
        pulses++;
        rdy_at = k + 3;
      end
    end
    checks++;
    if (pulses != 6) begin
      errors++;
      $display("FAIL conv_count: got %0d pulses, expected 6", pulses);
    end
  endtask

  task automatic test_mid_reset();
    exp_t e;
    drive_edge(1'b1, 16'h9999);
    void'(sb.pop_front());
    for (int n = 0; n < 4 && (k % 4) != 2; n++) begin
      drive_edge(1'b0, 16'h0000);
      void'(sb.pop_front());
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (an !== 4'b1111 || seg !== 7'b1111111 || conv_en !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: an=%b seg=%b conv_en=%b, expected an=1111 seg=1111111 conv_en=0",
               an, seg, conv_en);
    end
    reset  = 1'b1;
    k      = 0;
    m_held = 16'h0000;
    repeat (8) begin
      drive_edge(1'b0, 16'h0000);
      e = sb.pop_front();
      checks++;
      if (an !== e.an || seg !== e.seg || conv_en !== e.conv) begin
        errors++;
        $display("FAIL post_reset k=%0d: an=%b seg=%b conv_en=%b, expected an=%b seg=%b conv_en=%b",
                 k, an, seg, conv_en, e.an, e.seg, e.conv);
      end
    end
  endtask

  initial begin
    seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
                7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};
    reset  = 1'b0;
    rdy    = 1'b0;
    bcd_in = 16'h0000;
    test_reset();
    test_digits();
    test_tc_capture();
    test_conv_en();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
